// File: rtl/vga_scanout_pkg.sv
// Shared raster timing defaults, window geometry and pipeline record for the
// VGA read side. Same numbers are used by the drawing FSM and generators.
package vga_scanout_pkg;
  localparam int CW = 10;                 // raster counter width

  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BP_D     = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BP_D     = 33;

  localparam int WIN_X0_D   = 192;
  localparam int WIN_Y0_D   = 112;
  localparam int WIN_W_D    = 256;
  localparam int WIN_H_D    = 256;

  localparam logic [11:0] BG_COLOR_D = 12'h000;
  localparam bit          SYNC_POL_D = 1'b0;

  // Stage-1 record: everything the pin stage needs about one pixel.
  typedef struct packed {
    logic hs;       // raw hsync asserted
    logic vs;       // raw vsync asserted
    logic active;   // inside the visible 640x480 area
    logic in_win;   // inside the framebuffer window
  } s1_t;

  // Half-open range test on an unsigned counter value.
  function automatic logic in_range(input logic [CW-1:0] v, input int lo, input int n);
    return (int'(v) >= lo) && (int'(v) < lo + n);
  endfunction
endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters plus the undelayed timing flags derived from them.
module vga_timing_gen
  import vga_scanout_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_en,
  output logic [CW-1:0] h_cnt,
  output logic [CW-1:0] v_cnt,
  output logic          hs_raw,
  output logic          vs_raw,
  output logic          active,
  output logic          vblank,
  output logic          frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic h_last, v_last;

  assign h_last = (int'(h_cnt) == H_TOTAL - 1);
  assign v_last = (int'(v_cnt) == V_TOTAL - 1);

  assign hs_raw = in_range(h_cnt, H_ACTIVE + H_FP, H_SYNC);
  assign vs_raw = in_range(v_cnt, V_ACTIVE + V_FP, V_SYNC);
  assign active = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
  assign vblank = (int'(v_cnt) >= V_ACTIVE);

  // Advance the raster one pixel per enable; frame_start flags the step into (0,0).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && h_last && v_last;
      if (pix_en) begin
        if (h_last) begin
          h_cnt <= '0;
          v_cnt <= v_last ? '0 : v_cnt + CW'(1);
        end else begin
          h_cnt <= h_cnt + CW'(1);
        end
      end
    end
  end
endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: raster timing, 256x256 window decode, framebuffer read and
// a two-step pixel pipeline so RGB and syncs reach the pins together.
module vga_scanout
  import vga_scanout_pkg::*;
#(
  parameter int          H_ACTIVE = H_ACTIVE_D,
  parameter int          H_FP     = H_FP_D,
  parameter int          H_SYNC   = H_SYNC_D,
  parameter int          H_BP     = H_BP_D,
  parameter int          V_ACTIVE = V_ACTIVE_D,
  parameter int          V_FP     = V_FP_D,
  parameter int          V_SYNC   = V_SYNC_D,
  parameter int          V_BP     = V_BP_D,
  parameter int          WIN_X0   = WIN_X0_D,
  parameter int          WIN_Y0   = WIN_Y0_D,
  parameter int          WIN_W    = WIN_W_D,
  parameter int          WIN_H    = WIN_H_D,
  parameter logic [11:0] BG_COLOR = BG_COLOR_D,
  parameter bit          SYNC_POL = SYNC_POL_D
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  output logic [15:0] fb_rdaddr,
  output logic        fb_rden,
  input  logic [11:0] fb_q,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vblank,
  output logic        frame_start
);
  logic [CW-1:0] h_cnt, v_cnt;
  logic          hs_raw, vs_raw, active, in_win;
  logic [7:0]    x_rel, y_rel;
  s1_t           s1;
  logic          pe_d;
  logic [11:0]   q_hold, q_pix, rgb;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_tgen (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_en      (pix_en),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .hs_raw      (hs_raw),
    .vs_raw      (vs_raw),
    .active      (active),
    .vblank      (vblank),
    .frame_start (frame_start)
  );

  // Unsigned 10-bit offsets; only the low byte addresses the buffer.
  assign x_rel     = 8'(h_cnt - CW'(WIN_X0));
  assign y_rel     = 8'(v_cnt - CW'(WIN_Y0));
  assign in_win    = in_range(h_cnt, WIN_X0, WIN_W) && in_range(v_cnt, WIN_Y0, WIN_H);
  assign fb_rdaddr = {y_rel, x_rel};
  assign fb_rden   = in_win;

  // fb_q is only guaranteed to belong to the S1 pixel in the clock right after
  // the enable that loaded S1. With sparse enables the address moves on before
  // the next enable, so that word is held and used instead of the live bus.
  assign q_pix = pe_d ? fb_q : q_hold;

  // Capture the read word for the pixel sitting in S1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pe_d   <= 1'b0;
      q_hold <= '0;
    end else begin
      pe_d <= pix_en;
      if (pe_d) q_hold <= fb_q;
    end
  end

  // S1: register the undelayed timing flags alongside the issued read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= '0;
    end else if (pix_en) begin
      s1 <= '{hs: hs_raw, vs: vs_raw, active: active, in_win: in_win};
    end
  end

  // S2: pin stage; blanking forces black whatever the buffer returns.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rgb    <= '0;
      vga_hs <= ~SYNC_POL;
      vga_vs <= ~SYNC_POL;
    end else if (pix_en) begin
      rgb    <= s1.in_win ? q_pix : (s1.active ? BG_COLOR : 12'h000);
      vga_hs <= s1.hs ? SYNC_POL : ~SYNC_POL;
      vga_vs <= s1.vs ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign vga_r = rgb[11:8];
  assign vga_g = rgb[7:4];
  assign vga_b = rgb[3:0];
endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout. Horizontal timing is the real 800-clock line; the
// vertical size and window height are shrunk (22 lines, window rows 4..11)
// so whole frames fit in a short run. BG_COLOR is non-zero so it can be
// told apart from blanking.
module tb_vga_scanout;
  localparam int HT = 800;
  localparam int VT = 22;
  localparam int FRAME = HT * VT;
  localparam logic [11:0] BG = 12'h5A5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_en = 1'b1;
  logic        force_q = 1'b0;
  logic [11:0] fb_q;
  logic [15:0] fb_rdaddr;
  logic        fb_rden;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vblank, frame_start;

  int checks = 0;
  int fails  = 0;
  int cur    = 0;   // linear raster position the bench believes the DUT is at
  int fs_cnt = 0;

  vga_scanout #(
    .V_ACTIVE(16), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .WIN_Y0(4), .WIN_H(8), .BG_COLOR(BG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .fb_rdaddr(fb_rdaddr), .fb_rden(fb_rden), .fb_q(fb_q),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vblank(vblank), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // RAM model: one-clock read, data equals the low 12 address bits.
  always @(posedge clk) fb_q <= force_q ? 12'hFFF : fb_rdaddr[11:0];

  always @(negedge clk) if (frame_start) fs_cnt <= fs_cnt + 1;

  typedef struct {
    int          h;
    int          v;
    bit          frc;
    bit          ca;
    logic [15:0] addr;
    bit          rden;
    logic [11:0] rgb;
    bit          hs;
    bit          vs;
    bit          vb;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int h, int v, bit frc, bit ca, logic [15:0] a,
                              bit rd, logic [11:0] c, bit hs, bit vs, bit vb);
    vec_t r;
    r.h = h; r.v = v; r.frc = frc; r.ca = ca; r.addr = a; r.rden = rd;
    r.rgb = c; r.hs = hs; r.vs = vs; r.vb = vb;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    if (pix_en) cur = (cur + 1) % FRAME;
  endtask

  task automatic goto(input int h, input int v);
    int t, d;
    t = v * HT + h;
    d = (t >= cur) ? t - cur : t + FRAME - cur;
    repeat (d) step();
  endtask

  function automatic logic [11:0] pins();
    return {vga_r, vga_g, vga_b};
  endfunction

  initial begin
    int f1, r1, f2, vs_low, frm, fs_base;
    logic ph;

    // h, v, force_q, check addr, addr, rden, rgb at +2, hs, vs, vblank
    tbl.push_back(mk(192,  4, 0, 1, 16'h0000, 1, 12'h000, 1, 1, 0));
    tbl.push_back(mk(191,  5, 0, 0, 16'h0000, 0, BG,      1, 1, 0));
    tbl.push_back(mk(200,  5, 0, 1, 16'h0108, 1, 12'h108, 1, 1, 0));
    tbl.push_back(mk(447,  5, 0, 1, 16'h01FF, 1, 12'h1FF, 1, 1, 0));
    tbl.push_back(mk(448,  5, 0, 0, 16'h0000, 0, BG,      1, 1, 0));
    tbl.push_back(mk(639,  5, 0, 0, 16'h0000, 0, BG,      1, 1, 0));
    tbl.push_back(mk(640,  5, 1, 0, 16'h0000, 0, 12'h000, 1, 1, 0));
    tbl.push_back(mk(654,  5, 1, 0, 16'h0000, 0, 12'h000, 1, 1, 0));
    tbl.push_back(mk(656,  5, 1, 0, 16'h0000, 0, 12'h000, 0, 1, 0));
    tbl.push_back(mk(750,  5, 1, 0, 16'h0000, 0, 12'h000, 0, 1, 0));
    tbl.push_back(mk(752,  5, 1, 0, 16'h0000, 0, 12'h000, 1, 1, 0));
    tbl.push_back(mk(799,  5, 1, 0, 16'h0000, 0, 12'h000, 1, 1, 0));
    tbl.push_back(mk(255,  7, 0, 1, 16'h033F, 1, 12'h33F, 1, 1, 0));
    tbl.push_back(mk(192, 11, 0, 1, 16'h0700, 1, 12'h700, 1, 1, 0));
    tbl.push_back(mk(192, 12, 0, 0, 16'h0000, 0, BG,      1, 1, 0));
    tbl.push_back(mk( 10, 16, 1, 0, 16'h0000, 0, 12'h000, 1, 1, 1));
    tbl.push_back(mk( 10, 18, 1, 0, 16'h0000, 0, 12'h000, 1, 0, 1));
    tbl.push_back(mk( 10, 20, 1, 0, 16'h0000, 0, 12'h000, 1, 1, 1));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rgb", pins(), 12'h000);
    chk("rst_hs", vga_hs, 1'b1);
    chk("rst_vs", vga_vs, 1'b1);
    chk("rst_rden", fb_rden, 1'b0);
    chk("rst_fs", frame_start, 1'b0);
    chk("rst_vblank", vblank, 1'b0);
    rst_n = 1'b1;
    cur = 0;

    // Directed pixel vectors, frame 0
    foreach (tbl[i]) begin
      goto(tbl[i].h, tbl[i].v);
      force_q = tbl[i].frc;
      chk($sformatf("v%0d_rden", i), fb_rden, tbl[i].rden);
      chk($sformatf("v%0d_vblank", i), vblank, tbl[i].vb);
      if (tbl[i].ca) chk($sformatf("v%0d_addr", i), fb_rdaddr, tbl[i].addr);
      step();
      step();
      chk($sformatf("v%0d_rgb", i), pins(), tbl[i].rgb);
      chk($sformatf("v%0d_hs", i), vga_hs, tbl[i].hs);
      chk($sformatf("v%0d_vs", i), vga_vs, tbl[i].vs);
    end
    force_q = 1'b0;

    // Frame wrap: single-clock frame_start, vblank falls on the same edge
    goto(799, 21);
    chk("wrap_pre_vb", vblank, 1'b1);
    chk("wrap_pre_fs", frame_start, 1'b0);
    step();
    chk("wrap_fs", frame_start, 1'b1);
    chk("wrap_vb", vblank, 1'b0);
    step();
    chk("wrap_fs_drop", frame_start, 1'b0);

    // One frame with pix_en high: sync widths and frame length
    f1 = -1; r1 = -1; f2 = -1; vs_low = 0; frm = -1;
    ph = vga_hs;
    for (int i = 1; i <= FRAME + 2000 && frm < 0; i++) begin
      @(posedge clk); #1;
      if (ph && !vga_hs) begin
        if (f1 < 0) f1 = i;
        else if (f2 < 0) f2 = i;
      end
      if (!ph && vga_hs && f1 >= 0 && r1 < 0) r1 = i;
      ph = vga_hs;
      if (!vga_vs) vs_low++;
      if (frame_start) frm = i;
    end
    chk("hs_period", f2 - f1, 800);
    chk("hs_low", r1 - f1, 96);
    chk("vs_low", vs_low, 1600);
    chk("frame_len", frm, FRAME - 1);
    cur = 0;

    // pix_en every third clock across the left window edge
    goto(190, 5);
    for (int j = 1; j <= 10; j++) begin
      logic [11:0] exp_rgb;
      int x;
      x = 188 + j;
      exp_rgb = (x < 192) ? BG : 12'h100 + 12'(x - 192);
      pix_en = 1'b1;
      @(posedge clk); #1;
      pix_en = 1'b0;
      cur++;
      chk($sformatf("sp%0d_rgb", j), pins(), exp_rgb);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk($sformatf("sp%0d_hold", j), pins(), exp_rgb);
      chk($sformatf("sp%0d_rden", j), fb_rden, (j >= 2));
      if (j >= 2) chk($sformatf("sp%0d_addr", j), fb_rdaddr, 16'h0100 + 16'(j - 2));
    end
    pix_en = 1'b1;

    // Reset mid-line at (300,12), then restart from (0,0)
    goto(300, 12);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cur = 0;
    fs_base = fs_cnt;
    chk("mrst_rgb", pins(), 12'h000);
    chk("mrst_hs", vga_hs, 1'b1);
    chk("mrst_vs", vga_vs, 1'b1);
    chk("mrst_rden", fb_rden, 1'b0);
    chk("mrst_fs", frame_start, 1'b0);
    step();
    chk("mrst_rgb1", pins(), 12'h000);
    goto(191, 4);
    chk("mrst_191_rden", fb_rden, 1'b0);
    step();
    chk("mrst_192_rden", fb_rden, 1'b1);
    chk("mrst_192_addr", fb_rdaddr, 16'h0000);
    goto(799, 21);
    chk("mrst_no_fs", fs_cnt - fs_base, 0);
    step();
    chk("mrst_wrap_fs", frame_start, 1'b1);
    step();
    step();
    chk("mrst_fs_once", fs_cnt - fs_base, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
